// File: rtl/mssd_pkg.sv
// Shared types and constants for the parametrised serial demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default field widths, line levels, width helper.
package mssd_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_CNT  = 3'd2,
        S_DATA = 3'd3,
        S_PAR  = 3'd4,
        S_DONE = 3'd5
    } mssd_state_t;

    localparam int MSSD_ADDR_W = 2;
    localparam int MSSD_CNT_W  = 4;

    // Line is held high between frames; a low bit opens a frame.
    localparam logic MSSD_IDLE_LVL  = 1'b1;
    localparam logic MSSD_START_LVL = 1'b0;

    function automatic int mssd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_edge.sv
// Rising-edge strobe generator for a debounced push-button level.
// Latency: stb is combinational in the first cycle the level is seen high.
// Backpressure: none; one strobe per low-to-high transition.
// Ports: clk, rst (async active-high), pb (button level), stb (one-cycle strobe).
module pb_edge (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic stb
);

    logic pb_q;
    // A button already held down when reset releases must not count as a
    // press: strobes are only armed once the level has been seen low.
    logic armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            pb_q  <= pb;
            armed <= armed | ~pb;
        end
    end

    assign stb = pb & ~pb_q & armed;

endmodule

// File: rtl/mssd_param.sv
// Serial frame demux: start | addr | count | payload (| parity) routed to one-hot port P.
// Latency: serOut/SerOutValid zero-latency in the strobe cycle; done one cycle after the last strobe.
// Backpressure: none; every strobe is consumed, the sender paces via clkPB.
// Ports: clk, rst (async active-high), clkPB (bit strobe level), serIn (serial in, idle 1),
//        done (end-of-frame pulse), SerOutValid/serOut (payload bit), P (one-hot port select),
//        pdcnt (payload bits left), err (parity error).
// Build option: define MSSD_PARITY_EN to add a trailing even-parity bit and the err flag.
module mssd_param
    import mssd_pkg::*;
#(
    parameter int ADDR_W = MSSD_ADDR_W,
    parameter int CNT_W  = MSSD_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkPB,
    input  logic                     serIn,
    output logic                     done,
    output logic                     SerOutValid,
    output logic                     serOut,
    output logic [0:(1<<ADDR_W)-1]   P,
    output logic [CNT_W-1:0]         pdcnt,
    output logic                     err
);

    localparam int SH_W = mssd_max(ADDR_W, CNT_W);
    localparam int BC_W = $clog2(SH_W + 1);

`ifdef MSSD_PARITY_EN
    localparam mssd_state_t PAY_END = S_PAR;
`else
    localparam mssd_state_t PAY_END = S_DONE;
`endif

    mssd_state_t        state;
    logic               stb;
    logic [SH_W-1:0]    shreg;
    logic [SH_W-1:0]    next_sh;
    logic [BC_W-1:0]    bitcnt;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   cnt_in;
    logic               addr_last;
    logic               cnt_last;

    pb_edge u_pb (
        .clk (clk),
        .rst (rst),
        .pb  (clkPB),
        .stb (stb)
    );

    // Shared MSB-first shifter for both header fields; after N shifts the
    // low N bits hold the field just received.
    assign next_sh   = (shreg << 1) | SH_W'(serIn);
    assign cnt_in    = next_sh[CNT_W-1:0];
    assign addr_last = (bitcnt == BC_W'(ADDR_W - 1));
    assign cnt_last  = (bitcnt == BC_W'(CNT_W - 1));

`ifdef MSSD_PARITY_EN
    logic par;
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            addr   <= '0;
            pdcnt  <= '0;
`ifdef MSSD_PARITY_EN
            par    <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (stb && serIn == MSSD_START_LVL) begin
                        state  <= S_ADDR;
                        bitcnt <= '0;
`ifdef MSSD_PARITY_EN
                        par    <= 1'b0;
                        err_q  <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    if (stb) begin
                        shreg <= next_sh;
                        if (addr_last) begin
                            addr   <= next_sh[ADDR_W-1:0];
                            bitcnt <= '0;
                            state  <= S_CNT;
                        end else begin
                            bitcnt <= bitcnt + BC_W'(1);
                        end
                    end
                end
                S_CNT: begin
                    if (stb) begin
                        shreg <= next_sh;
                        if (cnt_last) begin
                            pdcnt  <= cnt_in;
                            bitcnt <= '0;
                            state  <= (cnt_in == '0) ? PAY_END : S_DATA;
                        end else begin
                            bitcnt <= bitcnt + BC_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (stb) begin
                        pdcnt <= pdcnt - CNT_W'(1);
`ifdef MSSD_PARITY_EN
                        par   <= par ^ serIn;
`endif
                        if (pdcnt == CNT_W'(1)) begin
                            state <= PAY_END;
                        end
                    end
                end
`ifdef MSSD_PARITY_EN
                S_PAR: begin
                    // Fold the parity bit in on the way to DONE so err is
                    // already valid while done is high.
                    if (stb) begin
                        par   <= par ^ serIn;
                        err_q <= par ^ serIn;
                        state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register: no input-to-output path.
    assign done = (state == S_DONE);

    always_comb begin
        P = '0;
        if (state == S_DATA || state == S_PAR || state == S_DONE) begin
            P[addr] = 1'b1;
        end
    end

    assign serOut      = serIn;
    assign SerOutValid = stb && (state == S_DATA);

endmodule

// File: tb/tb_mssd_param.sv
module tb_mssd_param;

`ifdef MSSD_PARITY_EN
    localparam int PARB = 1;
`else
    localparam int PARB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clkPB = 1'b0;
    logic serIn = 1'b1;

    always #5 clk = ~clk;

    logic       done0, v0, so0, err0;
    logic [0:3] P0;
    logic [3:0] pd0;
    logic       done1, v1, so1, err1;
    logic [0:7] P1;
    logic [4:0] pd1;

    mssd_param #(.ADDR_W(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .clkPB(clkPB), .serIn(serIn),
        .done(done0), .SerOutValid(v0), .serOut(so0), .P(P0), .pdcnt(pd0), .err(err0)
    );

    mssd_param #(.ADDR_W(3), .CNT_W(5)) dut1 (
        .clk(clk), .rst(rst), .clkPB(clkPB), .serIn(serIn),
        .done(done1), .SerOutValid(v1), .serOut(so1), .P(P1), .pdcnt(pd1), .err(err1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pmask(input logic [0:7] p);
        int r = 0;
        for (int a = 0; a < 8; a++) if (p[a] !== 1'b0) r |= (1 << a);
        return r;
    endfunction

    // Frame-position model: pos counts strobes accepted into the current frame.
    int AW[2] = '{2, 3};
    int CW[2] = '{4, 5};
    int pos[2], addr_m[2], cacc[2], rem[2];
    bit xo[2], err_m[2], ind[2];
    bit pbq_m, seenlow_m;

    // Observation logs for the directed literal checks.
    bit q0[$], q1[$];
    int dn0, dn1, pv0, pv1, pd0m, pd1m;
    logic ed0;

    logic       g_done, g_v, g_s, g_e;
    logic [31:0] g_pd;
    int         g_m, e_m, A, C, h, k;
    bit         stb_m, vexp, act;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst.u0.done", done0, 0);   chk("rst.u0.valid", v0, 0);
            chk("rst.u0.P", pmask({P0, 4'b0}), 0);
            chk("rst.u0.pdcnt", pd0, 0);    chk("rst.u0.err", err0, 0);
            chk("rst.u1.done", done1, 0);   chk("rst.u1.P", pmask(P1), 0);
            chk("rst.u1.pdcnt", pd1, 0);
            for (int i = 0; i < 2; i++) begin
                pos[i] = 0; addr_m[i] = 0; cacc[i] = 0; rem[i] = 0;
                xo[i] = 0; err_m[i] = 0; ind[i] = 0;
            end
            pbq_m = 0; seenlow_m = 0;
        end else begin
            stb_m = clkPB && !pbq_m && seenlow_m;
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    g_done = done0; g_v = v0; g_s = so0; g_e = err0;
                    g_pd = 32'(pd0); g_m = pmask({P0, 4'b0});
                end else begin
                    g_done = done1; g_v = v1; g_s = so1; g_e = err1;
                    g_pd = 32'(pd1); g_m = pmask(P1);
                end
                A = AW[i]; C = CW[i]; h = 1 + A + C;
                act  = ind[i] || (pos[i] >= h);
                vexp = stb_m && !ind[i] && pos[i] >= h && pos[i] < h + cacc[i];
                e_m  = act ? (1 << addr_m[i]) : 0;
                chk($sformatf("u%0d.done", i), g_done, ind[i]);
                chk($sformatf("u%0d.valid", i), g_v, vexp);
                chk($sformatf("u%0d.serOut", i), g_s, serIn);
                chk($sformatf("u%0d.P", i), g_m, e_m);
                chk($sformatf("u%0d.pdcnt", i), g_pd, rem[i]);
                chk($sformatf("u%0d.err", i), g_e, err_m[i]);

                // advance to the state after the coming rising edge
                if (ind[i]) begin
                    ind[i] = 0;
                end else if (stb_m) begin
                    if (pos[i] == 0) begin
                        if (!serIn) begin
                            pos[i] = 1; addr_m[i] = 0; cacc[i] = 0; xo[i] = 0; err_m[i] = 0;
                        end
                    end else begin
                        pos[i]++; k = pos[i];
                        if (k <= 1 + A) addr_m[i] = addr_m[i] * 2 + int'(serIn);
                        else if (k <= h) begin
                            cacc[i] = cacc[i] * 2 + int'(serIn);
                            if (k == h) rem[i] = cacc[i];
                        end else if (k <= h + cacc[i]) begin
                            rem[i]--; xo[i] ^= serIn;
                        end else begin
                            xo[i] ^= serIn; err_m[i] = xo[i];
                        end
                        if (k >= h && k == h + cacc[i] + PARB) begin
                            ind[i] = 1; pos[i] = 0;
                        end
                    end
                end
            end
            pbq_m = clkPB;
            seenlow_m = seenlow_m | !clkPB;

            if (v0) begin q0.push_back(so0); pv0 = pmask({P0, 4'b0}); end
            if (v1) begin q1.push_back(so1); pv1 = pmask(P1); end
            if (done0) begin dn0++; pd0m = pmask({P0, 4'b0}); ed0 = err0; end
            if (done1) begin dn1++; pd1m = pmask(P1); end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic b, input int hi, input int lo);
        serIn = b; clkPB = 1'b1;
        repeat (hi) tick();
        clkPB = 1'b0;
        repeat (lo) tick();
        serIn = 1'b1;
    endtask

    task automatic send(input logic [63:0] v, input int n, input int hi, input int lo);
        for (int j = n - 1; j >= 0; j--) press(v[j], hi, lo);
    endtask

    task automatic do_reset();
        rst = 1'b1; clkPB = 1'b0; serIn = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic clr_logs();
        q0.delete(); q1.delete();
        dn0 = 0; dn1 = 0; pv0 = 0; pv1 = 0; pd0m = 0; pd1m = 0; ed0 = 1'bx;
    endtask

    function automatic int qval(input bit q[$]);
        int r = 0;
        foreach (q[j]) r = r * 2 + int'(q[j]);
        return r;
    endfunction

    // default frame 0|01|0111|0110100 plus trailing 1 (parity when enabled, idle otherwise)
    localparam logic [14:0] DEF_FRAME = 15'b0_01_0111_0110100_1;

    task automatic check_default(input string tag);
        chk({tag, ".nvalid"}, q0.size(), 7);
        chk({tag, ".bits"}, qval(q0), 7'b0110100);
        chk({tag, ".P"}, pv0, 2);
        chk({tag, ".ndone"}, dn0, 1);
        chk({tag, ".donecount_pd"}, pd0, 0);
    endtask

    logic [63:0] rv;
    int rn, rg, ra, rc, rhi, rlo, rcut;

    initial begin
        clr_logs();
        do_reset();
        chk("init.P", pmask({P0, 4'b0}), 0);
        chk("init.pdcnt", pd0, 0);
        chk("init.done", done0, 0);

        // reset mid-frame: start bit + one address bit, then reset
        press(1'b0, 1, 2);
        press(1'b0, 1, 2);
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick(); tick();
        chk("midrst.P", pmask({P0, 4'b0}), 0);
        chk("midrst.pdcnt", pd0, 0);
        chk("midrst.ndone", dn0, 0);

        // default-width frame, then idle ones ignored
        clr_logs();
        send(64'(DEF_FRAME), 15, 1, 2);
        press(1'b1, 1, 2); press(1'b1, 1, 3);
        check_default("dflt");
        if (PARB != 0) chk("dflt.err", ed0, 0);

        // zero-length frame 0|11|0000 (+ even parity 0)
        do_reset(); clr_logs();
        send(64'(7'b0_11_0000), 7, 1, 2);
        if (PARB != 0) press(1'b0, 1, 2);
        repeat (3) tick();
        chk("zero.nvalid", q0.size(), 0);
        chk("zero.ndone", dn0, 1);
        chk("zero.P", pd0m, 8);

        // long press: 20 cycles high per bit
        do_reset(); clr_logs();
        send(64'(DEF_FRAME), 15, 20, 3);
        repeat (3) tick();
        check_default("long");

        // wide instance: 0|101|00011|101 (+ parity 0)
        do_reset(); clr_logs();
        send(64'(12'b0_101_00011_101), 12, 1, 2);
        if (PARB != 0) press(1'b0, 1, 2);
        repeat (3) tick();
        chk("wide.nvalid", q1.size(), 3);
        chk("wide.bits", qval(q1), 3'b101);
        chk("wide.P", pv1, 32);
        chk("wide.ndone", dn1, 1);

`ifdef MSSD_PARITY_EN
        // bad parity: err rises with done, clears on next start bit
        do_reset(); clr_logs();
        send(64'(15'b0_01_0111_0110100_0), 15, 1, 2);
        repeat (2) tick();
        chk("par.ndone", dn0, 1);
        chk("par.err_at_done", ed0, 1);
        chk("par.err_held", err0, 1);
        press(1'b0, 1, 2);
        chk("par.err_cleared", err0, 0);
        send(64'(7'b00_0000_0), 7, 1, 2);
        repeat (2) tick();
        chk("par.ndone2", dn0, 2);
`endif

        // randomized frames on either geometry, with occasional mid-frame resets
        do_reset();
        for (int it = 0; it < 60; it++) begin
            rg = $urandom_range(0, 1);
            ra = $urandom_range(0, rg ? 7 : 3);
            rc = $urandom_range(0, 12);
            rv = 0; rn = 0;
            rv = (rv << 1); rn++;
            for (int j = (rg ? 2 : 1); j >= 0; j--) begin rv = (rv << 1) | 64'((ra >> j) & 1); rn++; end
            for (int j = (rg ? 4 : 3); j >= 0; j--) begin rv = (rv << 1) | 64'((rc >> j) & 1); rn++; end
            for (int j = 0; j < rc + PARB; j++) begin rv = (rv << 1) | 64'($urandom_range(0, 1)); rn++; end
            rhi = $urandom_range(1, 4);
            rlo = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) begin
                rcut = $urandom_range(1, rn - 1);
                send(rv >> (rn - rcut), rcut, rhi, rlo);
                rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
            end else begin
                send(rv, rn, rhi, rlo);
                repeat ($urandom_range(0, 2)) press(1'b1, rhi, rlo);
            end
        end
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog expired got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
